// File: rtl/sensor_uart_tx_if.sv
// Byte-stream handshake from the sensor/command source into the UART transmitter.
interface sensor_uart_tx_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/sensor_uart_tx.sv
// Sensor-side 8N1 UART transmitter fed from a small circular byte FIFO.
// Frames are sent back-to-back while bytes remain buffered.
module sensor_uart_tx #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD_RATE    = 115_200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    sensor_uart_tx_if.slave               s_bus,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          r_state;
    state_t          w_nextState;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wrPtr;
    logic [AW-1:0]   r_rdPtr;
    logic [CW-1:0]   r_count;

    logic [7:0]      r_shift;
    logic [BW-1:0]   r_baudCnt;
    logic [2:0]      r_bitIdx;
    logic            r_tx;

    logic            w_ready;
    logic            w_push;
    logic            w_pop;
    logic            w_notEmpty;
    logic            w_cellEnd;
    logic [2:0]      w_bitInc;
    logic            w_txNext;
    logic [BW-1:0]   w_baudNext;
    logic [2:0]      w_bitNext;

    // A full FIFO refuses input even when the FSM pops on the same edge.
    assign w_ready    = rst_n && (r_count != DEPTH_C);
    assign w_push     = s_bus.s_valid && w_ready;
    assign w_notEmpty = (r_count != '0);
    assign w_cellEnd  = (r_baudCnt == BAUD_LAST);
    assign w_bitInc   = r_bitIdx + 3'd1;

    assign s_bus.s_ready = w_ready;
    assign uart_tx       = r_tx;
    assign tx_busy       = (r_state != S_IDLE);
    assign fifo_count    = r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        w_txNext    = r_tx;
        w_baudNext  = r_baudCnt;
        w_bitNext   = r_bitIdx;
        case (r_state)
            S_IDLE: begin
                w_txNext   = 1'b1;
                w_baudNext = '0;
                w_bitNext  = '0;
                if (w_notEmpty) begin
                    w_pop       = 1'b1;
                    w_txNext    = 1'b0;
                    w_nextState = S_START;
                end
            end
            S_START: begin
                if (w_cellEnd) begin
                    w_baudNext  = '0;
                    w_bitNext   = '0;
                    w_txNext    = r_shift[0];
                    w_nextState = S_DATA;
                end else begin
                    w_baudNext = r_baudCnt + BW'(1);
                end
            end
            S_DATA: begin
                if (w_cellEnd) begin
                    w_baudNext = '0;
                    if (r_bitIdx == 3'd7) begin
                        w_txNext    = 1'b1;
                        w_nextState = S_STOP;
                    end else begin
                        w_bitNext = w_bitInc;
                        w_txNext  = r_shift[w_bitInc];
                    end
                end else begin
                    w_baudNext = r_baudCnt + BW'(1);
                end
            end
            S_STOP: begin
                if (w_cellEnd) begin
                    w_baudNext = '0;
                    // Chain straight into the next start bit when more bytes wait.
                    if (w_notEmpty) begin
                        w_pop       = 1'b1;
                        w_txNext    = 1'b0;
                        w_nextState = S_START;
                    end else begin
                        w_txNext    = 1'b1;
                        w_nextState = S_IDLE;
                    end
                end else begin
                    w_baudNext = r_baudCnt + BW'(1);
                end
            end
            default: begin
                w_txNext    = 1'b1;
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx      <= 1'b1;
            r_baudCnt <= '0;
            r_bitIdx  <= '0;
            r_shift   <= '0;
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
        end else begin
            r_tx      <= w_txNext;
            r_baudCnt <= w_baudNext;
            r_bitIdx  <= w_bitNext;
            if (w_pop) begin
                r_shift <= r_mem[r_rdPtr];
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= s_bus.s_data;
        end
    end

endmodule
